// File: rtl/stack_controller.sv
// LIFO sequencer for a single-port synchronous RAM: turns push/pop requests into
// RAM write/read cycles and tracks stack occupancy, full/empty and misuse.
module stack_controller #(
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned DATA_SIZE    = 8
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic                    push_request,
  input  logic                    pop_request,
  input  logic [DATA_SIZE-1:0]    push_data,
  input  logic [DATA_SIZE-1:0]    ram_read_data,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic                    ram_write_enable,
  output logic [DATA_SIZE-1:0]    ram_write_data,
  output logic [DATA_SIZE-1:0]    pop_data,
  output logic                    pop_valid,
  output logic                    busy,
  output logic                    full,
  output logic                    empty,
  output logic                    error,
  output logic [ADDRESS_SIZE:0]   stack_count
);

  localparam int unsigned COUNT_W = ADDRESS_SIZE + 1;
  localparam logic [COUNT_W-1:0] DEPTH = COUNT_W'(1) << ADDRESS_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    PUSH_WRITE,
    POP_ADDRESS,
    POP_WAIT
  } state_t;

  state_t                  state, state_next;
  logic [ADDRESS_SIZE-1:0] address_next;
  logic                    write_enable_next;
  logic [DATA_SIZE-1:0]    write_data_next;
  logic [DATA_SIZE-1:0]    pop_data_next;
  logic                    pop_valid_next;
  logic                    busy_next;
  logic                    full_next;
  logic                    empty_next;
  logic                    error_next;
  logic [COUNT_W-1:0]      count_next;

  // State and every output are registered; reset aborts any in-flight access.
  always_ff @(posedge control_clock) begin
    if (reset) begin
      state            <= IDLE;
      ram_address      <= '0;
      ram_write_enable <= 1'b0;
      ram_write_data   <= '0;
      pop_data         <= '0;
      pop_valid        <= 1'b0;
      busy             <= 1'b0;
      full             <= 1'b0;
      empty            <= 1'b1;
      error            <= 1'b0;
      stack_count      <= '0;
    end else begin
      state            <= state_next;
      ram_address      <= address_next;
      ram_write_enable <= write_enable_next;
      ram_write_data   <= write_data_next;
      pop_data         <= pop_data_next;
      pop_valid        <= pop_valid_next;
      busy             <= busy_next;
      full             <= full_next;
      empty            <= empty_next;
      error            <= error_next;
      stack_count      <= count_next;
    end
  end

  // Next-state and next-output logic; push has priority over pop in IDLE.
  always_comb begin
    state_next        = state;
    address_next      = ram_address;
    write_enable_next = 1'b0;
    write_data_next   = ram_write_data;
    pop_data_next     = pop_data;
    pop_valid_next    = 1'b0;
    busy_next         = busy;
    error_next        = 1'b0;
    count_next        = stack_count;

    case (state)
      IDLE: begin
        if (push_request) begin
          if (!full) begin
            address_next      = ADDRESS_SIZE'(stack_count);
            write_data_next   = push_data;
            write_enable_next = 1'b1;
            busy_next         = 1'b1;
            state_next        = PUSH_WRITE;
          end else begin
            error_next = 1'b1;
          end
        end else if (pop_request) begin
          if (!empty) begin
            address_next = ADDRESS_SIZE'(stack_count - COUNT_W'(1));
            busy_next    = 1'b1;
            state_next   = POP_ADDRESS;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      PUSH_WRITE: begin
        count_next = stack_count + COUNT_W'(1);
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      POP_ADDRESS: begin
        state_next = POP_WAIT;
      end
      POP_WAIT: begin
        pop_data_next  = ram_read_data;
        pop_valid_next = 1'b1;
        count_next     = stack_count - COUNT_W'(1);
        busy_next      = 1'b0;
        state_next     = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase

    full_next  = (count_next == DEPTH);
    empty_next = (count_next == '0);
  end

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller (ADDRESS_SIZE=2): a behavioural RAM plus a queue-based
// LIFO model supply the expected values for directed and random request traffic.
module tb_stack_controller;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 4;

  logic          control_clock = 1'b0;
  logic          reset = 1'b1;
  logic          push_request = 1'b0;
  logic          pop_request = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] ram_read_data;
  logic [AW-1:0] ram_address;
  logic          ram_write_enable;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          busy;
  logic          full;
  logic          empty;
  logic          error;
  logic [AW:0]   stack_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_last = '0;
  logic [DW-1:0] mem [DEPTH];

  stack_controller #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
    .control_clock    (control_clock),
    .reset            (reset),
    .push_request     (push_request),
    .pop_request      (pop_request),
    .push_data        (push_data),
    .ram_read_data    (ram_read_data),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_write_data   (ram_write_data),
    .pop_data         (pop_data),
    .pop_valid        (pop_valid),
    .busy             (busy),
    .full             (full),
    .empty            (empty),
    .error            (error),
    .stack_count      (stack_count)
  );

  always #5 control_clock = ~control_clock;

  // Single-port synchronous RAM: read data valid the cycle after the address edge.
  always @(posedge control_clock) begin
    if (ram_write_enable) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  task automatic step();
    @(posedge control_clock);
    #1;
  endtask

  // Push with the request held for one edge; reports what the accept edge produced.
  task automatic push_op(input logic [DW-1:0] d, output logic wrote, output int waddr,
                         output logic [DW-1:0] wdata, output logic err);
    push_request = 1'b1;
    push_data = d;
    step();
    push_request = 1'b0;
    wrote = ram_write_enable;
    waddr = int'(ram_address);
    wdata = ram_write_data;
    err = error;
    if (busy) step();
  endtask

  // Pop with the request held for one edge; lat = edges from accept to pop_valid.
  task automatic pop_op(output logic valid, output logic [DW-1:0] d, output int lat,
                        output logic err);
    pop_request = 1'b1;
    step();
    pop_request = 1'b0;
    err = error;
    valid = 1'b0;
    d = pop_data;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      if (pop_valid) begin
        valid = 1'b1;
        d = pop_data;
        break;
      end
      if (!busy && i > 0) break;
      step();
      lat++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_q.delete();
    model_last = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ram_address, ram_write_enable, ram_write_data, pop_data, pop_valid, busy,
         full, empty, error, stack_count} !== {2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0,
         1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%0d we=%b wd=%h pd=%h pv=%b busy=%b full=%b empty=%b err=%b cnt=%0d, want all zero with empty=1",
               ram_address, ram_write_enable, ram_write_data, pop_data, pop_valid, busy,
               full, empty, error, stack_count);
    end
  endtask

  task automatic test_lifo();
    logic wrote, err, valid;
    int waddr, lat;
    logic [DW-1:0] wdata, d;
    logic [DW-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      push_op(vals[i], wrote, waddr, wdata, err);
      checks++;
      if (wrote !== 1'b1 || waddr != i || wdata !== vals[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL lifo_push%0d: got we=%b addr=%0d wd=%h err=%b, want we=1 addr=%0d wd=%h err=0",
                 i, wrote, waddr, wdata, err, i, vals[i]);
      end
    end
    checks++;
    if (stack_count !== 3'd3) begin
      errors++;
      $display("FAIL lifo_count: got %0d want 3", stack_count);
    end
    for (int i = 2; i >= 0; i--) begin
      pop_op(valid, d, lat, err);
      checks++;
      if (valid !== 1'b1 || d !== vals[i] || lat != 2) begin
        errors++;
        $display("FAIL lifo_pop: got valid=%b data=%h latency=%0d, want valid=1 data=%h latency=2",
                 valid, d, lat, vals[i]);
      end
      step();
      checks++;
      if (pop_valid !== 1'b0) begin
        errors++;
        $display("FAIL lifo_pop_valid_width: pop_valid=%b one cycle later, want 0", pop_valid);
      end
    end
    model_last = 8'h11;
    checks++;
    if (empty !== 1'b1 || stack_count !== 3'd0) begin
      errors++;
      $display("FAIL lifo_empty: got empty=%b cnt=%0d, want empty=1 cnt=0", empty, stack_count);
    end
  endtask

  task automatic test_full_boundary();
    logic wrote, err;
    int waddr;
    logic [DW-1:0] wdata;
    logic saw_we = 1'b0;
    for (int i = 0; i < 4; i++) push_op(8'hA0 + 8'(i), wrote, waddr, wdata, err);
    checks++;
    if (full !== 1'b1 || stack_count !== 3'd4) begin
      errors++;
      $display("FAIL full_flag: got full=%b cnt=%0d, want full=1 cnt=4", full, stack_count);
    end
    // Hold an illegal push for three edges: error each cycle, never a write.
    push_request = 1'b1;
    push_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ram_write_enable) saw_we = 1'b1;
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL full_error_held%0d: got error=%b busy=%b, want error=1 busy=0", i, error, busy);
      end
    end
    push_request = 1'b0;
    step();
    if (ram_write_enable) saw_we = 1'b1;
    checks++;
    if (error !== 1'b0 || saw_we !== 1'b0 || stack_count !== 3'd4) begin
      errors++;
      $display("FAIL full_reject: got error=%b any_we=%b cnt=%0d, want error=0 any_we=0 cnt=4",
               error, saw_we, stack_count);
    end
    for (int i = 0; i < 4; i++) model_q.push_back(8'hA0 + 8'(i));
  endtask

  task automatic test_empty_boundary();
    logic valid, err;
    logic [DW-1:0] d;
    int lat;
    apply_reset();
    push_op(8'h5A, valid, lat, d, err);
    pop_op(valid, d, lat, err);
    model_last = 8'h5A;
    pop_request = 1'b1;
    step();
    pop_request = 1'b0;
    checks++;
    if (error !== 1'b1 || pop_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_error: got error=%b pv=%b busy=%b, want error=1 pv=0 busy=0", error, pop_valid, busy);
    end
    step();
    step();
    checks++;
    if (error !== 1'b0 || pop_valid !== 1'b0 || pop_data !== 8'h5A || stack_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_after: got error=%b pv=%b pd=%h cnt=%0d, want error=0 pv=0 pd=5a cnt=0",
               error, pop_valid, pop_data, stack_count);
    end
  endtask

  task automatic test_simultaneous_and_busy();
    logic wrote, err;
    int waddr;
    logic [DW-1:0] wdata;
    logic saw_pv = 1'b0;
    apply_reset();
    push_op(8'h01, wrote, waddr, wdata, err);
    push_request = 1'b1;
    pop_request = 1'b1;
    push_data = 8'h02;
    step();
    push_request = 1'b0;
    pop_request = 1'b0;
    checks++;
    if (ram_write_enable !== 1'b1 || ram_address !== 2'd1 || ram_write_data !== 8'h02) begin
      errors++;
      $display("FAIL simul_push_wins: got we=%b addr=%0d wd=%h, want we=1 addr=1 wd=02",
               ram_write_enable, ram_address, ram_write_data);
    end
    step();
    checks++;
    if (stack_count !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_count: got cnt=%0d busy=%b, want cnt=2 busy=0", stack_count, busy);
    end
    // Pop pulsed only while a push is in flight must be ignored.
    push_request = 1'b1;
    push_data = 8'h03;
    step();
    push_request = 1'b0;
    pop_request = 1'b1;
    step();
    pop_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pop_valid || busy) saw_pv = 1'b1;
      step();
    end
    checks++;
    if (saw_pv !== 1'b0 || stack_count !== 3'd3) begin
      errors++;
      $display("FAIL busy_ignore: got pop_activity=%b cnt=%0d, want 0 and cnt=3", saw_pv, stack_count);
    end
  endtask

  task automatic test_reset_mid_op();
    logic wrote, err;
    int waddr;
    logic [DW-1:0] wdata;
    logic saw_pv = 1'b0;
    apply_reset();
    push_request = 1'b1;
    push_data = 8'h77;
    step();
    push_request = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (ram_write_enable !== 1'b0 || stack_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_push: got we=%b cnt=%0d busy=%b, want we=0 cnt=0 busy=0",
               ram_write_enable, stack_count, busy);
    end
    reset = 1'b0;
    push_op(8'h66, wrote, waddr, wdata, err);
    pop_request = 1'b1;
    step();
    pop_request = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pop_valid) saw_pv = 1'b1;
      step();
    end
    checks++;
    if (saw_pv !== 1'b0 || stack_count !== 3'd0 || pop_data !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_pop: got pv_seen=%b cnt=%0d pd=%h empty=%b, want 0, 0, 00, 1",
               saw_pv, stack_count, pop_data, empty);
    end
    model_q.delete();
    model_last = '0;
  endtask

  task automatic test_random();
    logic wrote, err, valid;
    int waddr, lat, kind;
    logic [DW-1:0] wdata, d, v;
    int exp_addr;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      v = 8'($urandom);
      if (kind < 4 || kind == 9) begin
        // kind 9 raises both requests; push must win.
        exp_addr = model_q.size();
        pop_request = (kind == 9);
        push_op(v, wrote, waddr, wdata, err);
        pop_request = 1'b0;
        checks++;
        if (exp_addr < DEPTH) begin
          model_q.push_back(v);
          if (wrote !== 1'b1 || waddr != exp_addr || wdata !== v || err !== 1'b0) begin
            errors++;
            $display("FAIL rand_push n=%0d: got we=%b addr=%0d wd=%h err=%b, want we=1 addr=%0d wd=%h err=0",
                     n, wrote, waddr, wdata, err, exp_addr, v);
          end
        end else if (wrote !== 1'b0 || err !== 1'b1) begin
          errors++;
          $display("FAIL rand_push_full n=%0d: got we=%b err=%b, want we=0 err=1", n, wrote, err);
        end
      end else if (kind < 8) begin
        pop_op(valid, d, lat, err);
        checks++;
        if (model_q.size() > 0) begin
          model_last = model_q.pop_back();
          if (valid !== 1'b1 || d !== model_last || lat != 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL rand_pop n=%0d: got valid=%b data=%h lat=%0d err=%b, want valid=1 data=%h lat=2 err=0",
                     n, valid, d, lat, err, model_last);
          end
        end else if (valid !== 1'b0 || err !== 1'b1 || pop_data !== model_last) begin
          errors++;
          $display("FAIL rand_pop_empty n=%0d: got valid=%b err=%b pd=%h, want valid=0 err=1 pd=%h",
                   n, valid, err, pop_data, model_last);
        end
      end else begin
        step();
      end
      checks++;
      if (stack_count !== 3'(model_q.size()) || full !== (model_q.size() == DEPTH) ||
          empty !== (model_q.size() == 0) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_status n=%0d: got cnt=%0d full=%b empty=%b busy=%b, want cnt=%0d full=%b empty=%b busy=0",
                 n, stack_count, full, empty, busy, model_q.size(),
                 model_q.size() == DEPTH, model_q.size() == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full_boundary();
    test_empty_boundary();
    test_simultaneous_and_busy();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
